pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit; the next generation of the team's 4-bit combinational adder. Operands of WIDTH bits are split into SEG-bit segments, and one segment is resolved per pipeline stage with a registered carry chain. Results come out with carry/borrow and signed-overflow flags. The block sits between a valid/ready producer and a consumer in the datapath and sustains one operation per cycle when not back-pressured.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; must be a multiple of SEG.
- SEG, 4: segment width resolved per stage.
- STAGES is derived as WIDTH/SEG and is not overridable.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block accepts the operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub).
- ovf  output  1  two's-complement signed overflow of sum[WIDTH−1:0].

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Pipeline enable: `adv = !out_valid || out_ready`. All stages advance together when adv is high and hold otherwise.
- in_ready = adv, which is combinational from out_ready and out_valid. Bubbles advance with the pipeline and are not compressed.
- Sub mode: B is inverted and carry-in is 1 at stage 0. Operand segments not yet consumed are delayed alongside their stage.
- Stage k computes the segment sum of a_k, b_k' and carry_{k−1}. It registers the SEG result bits and carry_k, with a valid bit and the sub flag.
- Final stage assembles the result:
  - sum[WIDTH−1:0] = (A ± B) mod 2^WIDTH.
  - Add: sum[WIDTH] = carry out.
  - Sub: sum[WIDTH] = NOT carry out, i.e. borrow = 1 iff A < B unsigned.
  - ovf, add: a[MSB]==b[MSB] && sum[MSB]!=a[MSB].
  - ovf, sub: a[MSB]!=b[MSB] && sum[MSB]!=a[MSB].
- sum and ovf are only meaningful while out_valid=1. They are held stable while out_valid && !out_ready.
- WIDTH==SEG is legal and gives a single-stage registered adder.

## Timing
- Latency: operand accepted at edge n gives out_valid=1 after edge n+STAGES−1, i.e. visible in the cycle following edge n+STAGES−1 when unstalled. With STAGES registers, the result appears STAGES cycles after acceptance.
- Throughput: 1 result/cycle with out_ready held high.
- Stall: out_valid && !out_ready freezes every stage. in_ready=0 that cycle and no data is lost or reordered.
- Simultaneous out-transfer and in-transfer in the same cycle is legal and keeps full throughput.
- Reset, synchronous:
  - Clears all stage valid bits: out_valid=0, sum=0, ovf=0, and in_ready=1 in the cycle after.
  - Reset mid-operation discards all in-flight operations.
  - Inputs presented during reset are not accepted.
- Carry is registered between stages, so the longest combinational path is one SEG-bit add plus flag logic.

## Structure
- Shared include `adder_defs.vh`: mode encodings (ADD=0, SUB=1) and the STAGES derivation macro, reused by the testbench.
- Sub-module `adder_stage`: one SEG-bit segment adder plus its valid/carry/operand-delay registers with enable. It is instantiated STAGES times in a generate loop.
- The top level holds enable/handshake logic, final assembly and flags. Elaboration-time check: WIDTH % SEG == 0, else $error.

## Test plan
Default WIDTH=8, SEG=4 (2 stages), out_ready=1 unless stated.

- a=0x0F, b=0x01, add: carry crosses the segment; sum=0x010, ovf=0, out_valid exactly 2 cycles after acceptance.
- a=0xFF, b=0x01, add: sum=0x100, ovf=0. a=0x7F, b=0x01: sum=0x080, ovf=1.
- a=0x03, b=0x05, sub: sum=0x1FE (borrow=1), ovf=0. a=0x80, b=0x01, sub: sum=0x07F, ovf=1.
- Back-to-back inputs (2+3, 5+6, 9+6):
  - Hold out_ready=0 for 3 cycles.
  - Required: in_ready drops, first result 0x005 held stable.
  - After release, results 0x005, 0x00B, 0x00F in order with no loss or duplication.
- Reset asserted one cycle after accepting 5+6: out_valid stays 0 and no result emerges. After reset, a new 15+1 gives 0x010.
- WIDTH=4, SEG=4 (1 stage): vectors 0+0, 2+3, 5+6, 15+1, 9+6 give 0x00, 0x05, 0x0B, 0x10, 0x0F with 1-cycle latency.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared mode encodings and stage-count derivation
package pipelined_adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// rtl/adder_stage.sv - one SEG-bit segment of the add/sub chain with its pipeline registers
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             prev_valid,
    input  logic             prev_sub,
    input  logic             prev_carry,
    input  logic [WIDTH-1:0] prev_a,
    input  logic [WIDTH-1:0] prev_b,
    input  logic [WIDTH-1:0] prev_r,
    output logic             valid,
    output logic             sub,
    output logic             carry,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r
);

    logic [SEG-1:0]   a_seg;
    logic [SEG-1:0]   b_seg;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] next_r;

    // Subtraction inverts B here; the +1 enters as stage 0's carry-in.
    assign a_seg   = prev_a[IDX*SEG +: SEG];
    assign b_seg   = prev_b[IDX*SEG +: SEG] ^ {SEG{prev_sub == MODE_SUB}};
    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, prev_carry};

    always_comb begin
        next_r                   = prev_r;
        next_r[IDX*SEG +: SEG]   = seg_sum[SEG-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            sub   <= 1'b0;
            carry <= 1'b0;
            a     <= '0;
            b     <= '0;
            r     <= '0;
        end else if (en) begin
            valid <= prev_valid;
            sub   <= prev_sub;
            carry <= seg_sum[SEG];
            a     <= prev_a;
            b     <= prev_b;
            r     <= next_r;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - segmented pipelined add/sub with carry/borrow and overflow flags
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int STAGES = stages_of(WIDTH, SEG);

    generate
        if ((WIDTH % SEG) != 0) begin : g_bad_width
            $error("pipelined_adder: WIDTH must be a multiple of SEG");
        end
    endgenerate

    logic             adv;
    logic [STAGES:0]  pv;
    logic [STAGES:0]  ps;
    logic [STAGES:0]  pc;
    logic [WIDTH-1:0] pa [STAGES+1];
    logic [WIDTH-1:0] pb [STAGES+1];
    logic [WIDTH-1:0] pr [STAGES+1];

    // Whole pipeline moves in lockstep; bubbles are carried, not squeezed out.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign pv[0] = in_valid;
    assign ps[0] = sub;
    assign pc[0] = (sub == MODE_SUB);
    assign pa[0] = a;
    assign pb[0] = b;
    assign pr[0] = '0;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            adder_stage #(
                .WIDTH (WIDTH),
                .SEG   (SEG),
                .IDX   (k)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .en         (adv),
                .prev_valid (pv[k]),
                .prev_sub   (ps[k]),
                .prev_carry (pc[k]),
                .prev_a     (pa[k]),
                .prev_b     (pb[k]),
                .prev_r     (pr[k]),
                .valid      (pv[k+1]),
                .sub        (ps[k+1]),
                .carry      (pc[k+1]),
                .a          (pa[k+1]),
                .b          (pb[k+1]),
                .r          (pr[k+1])
            );
        end
    endgenerate

    logic a_msb;
    logic b_msb;
    logic r_msb;
    logic last_sub;

    assign a_msb    = pa[STAGES][WIDTH-1];
    assign b_msb    = pb[STAGES][WIDTH-1];
    assign r_msb    = pr[STAGES][WIDTH-1];
    assign last_sub = (ps[STAGES] == MODE_SUB);

    assign out_valid = pv[STAGES];
    // Carry-out of A + ~B + 1 is the inverse of borrow.
    assign sum       = {pc[STAGES] ^ last_sub, pr[STAGES]};
    assign ovf       = ((a_msb == b_msb) ^ last_sub) && (r_msb != a_msb);

    logic unused_ok;
    assign unused_ok = ^{pa[STAGES], pb[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed self-checking bench for pipelined_adder
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, in_ready, sub, out_valid, out_ready, ovf;
    logic [7:0] a, b;
    logic [8:0] sum;

    logic       in_valid4, in_ready4, sub4, out_valid4, out_ready4, ovf4;
    logic [3:0] a4, b4;
    logic [4:0] sum4;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(8), .SEG(4)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(4), .SEG(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic mode, input logic [8:0] exp_sum, input logic exp_ovf);
        in_valid = 1'b1; a = av; b = bv; sub = mode;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    logic [3:0] va4 [5];
    logic [3:0] vb4 [5];
    logic [4:0] ve4 [5];

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = MODE_ADD; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = MODE_ADD; out_ready4 = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        op8("add_0f_01", 8'h0F, 8'h01, MODE_ADD, 9'h010, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, MODE_ADD, 9'h100, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, MODE_ADD, 9'h080, 1'b1);
        op8("sub_03_05", 8'h03, 8'h05, MODE_SUB, 9'h1FE, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, MODE_SUB, 9'h07F, 1'b1);
        step();
        chk("drain_idle", out_valid, 0);

        // Full throughput: 1+1, 2+2, 3+3 on consecutive cycles
        sub = MODE_ADD;
        in_valid = 1'b1; a = 8'd1; b = 8'd1;
        step();
        a = 8'd2; b = 8'd2;
        step();
        chk("tp_r0", sum, 9'h002);
        a = 8'd3; b = 8'd3;
        step();
        in_valid = 1'b0;
        chk("tp_r1", sum, 9'h004);
        step();
        chk("tp_r2", sum, 9'h006);
        chk("tp_r2_valid", out_valid, 1);
        step();
        chk("tp_idle", out_valid, 0);

        // Back-pressure: 2+3, 5+6, 9+6 with a 3-cycle stall
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'd2; b = 8'd3;
        #1;
        chk("bp_acc0_ready", in_ready, 1);
        step();
        a = 8'd5; b = 8'd6;
        chk("bp_acc1_ready", in_ready, 1);
        step();
        a = 8'd9; b = 8'd6;
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_in_ready", in_ready, 0);
            chk("bp_stall_valid", out_valid, 1);
            chk("bp_stall_sum", sum, 9'h005);
            if (i < 2) step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_r0", sum, 9'h005);
        step();
        in_valid = 1'b0;
        chk("bp_r1_valid", out_valid, 1);
        chk("bp_r1", sum, 9'h00B);
        step();
        chk("bp_r2_valid", out_valid, 1);
        chk("bp_r2", sum, 9'h00F);
        step();
        chk("bp_idle", out_valid, 0);

        // Reset one cycle after accepting 5+6; inputs during reset are ignored
        in_valid = 1'b1; a = 8'd5; b = 8'd6;
        step();
        a = 8'd1; b = 8'd1; reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_rst_v0", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        step();
        chk("mid_rst_v1", out_valid, 0);
        step();
        chk("mid_rst_v2", out_valid, 0);
        op8("post_rst_15_1", 8'd15, 8'd1, MODE_ADD, 9'h010, 1'b0);
        step();

        // Single-stage instance
        va4[0] = 4'd0;  vb4[0] = 4'd0; ve4[0] = 5'h00;
        va4[1] = 4'd2;  vb4[1] = 4'd3; ve4[1] = 5'h05;
        va4[2] = 4'd5;  vb4[2] = 4'd6; ve4[2] = 5'h0B;
        va4[3] = 4'd15; vb4[3] = 4'd1; ve4[3] = 5'h10;
        va4[4] = 4'd9;  vb4[4] = 4'd6; ve4[4] = 5'h0F;
        chk("w4_idle", out_valid4, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid4 = 1'b1; a4 = va4[i]; b4 = vb4[i];
            step();
            in_valid4 = 1'b0;
            chk("w4_valid", out_valid4, 1);
            chk("w4_sum", sum4, ve4[i]);
        end
        step();
        chk("w4_drain", out_valid4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
